// File: rtl/ps2_key_matrix.sv
// PS/2 keyboard receiver and scan-code decoder that maintains a 9x8 active-low
// key matrix (CPU row-select read-out), held F1..F11 state and held modifiers.
module ps2_key_matrix #(
  parameter int unsigned TIMEOUT = 96000
) (
  input  logic        clk_sys,
  input  logic        rst_n,
  input  logic        ps2_kbd_clk,
  input  logic        ps2_kbd_data,
  input  logic [15:0] addr,
  output logic [7:0]  key_data,
  output logic [11:1] Fn,
  output logic [2:0]  mod
);

  localparam int unsigned TO_W = $clog2(TIMEOUT + 1);

  typedef enum logic [2:0] {
    ST_IDLE,
    ST_EXT,
    ST_BRK,
    ST_EXT_BRK,
    ST_PAUSE
  } state_t;

  // Returns {hit, row[3:0], bit[2:0]} for a make/break code.
  function automatic logic [7:0] key_map(input logic [7:0] code);
    case (code)
      8'h12, 8'h59: key_map = 8'h80;
      8'h1A: key_map = 8'h81;  8'h22: key_map = 8'h82;  8'h21: key_map = 8'h83;
      8'h2A: key_map = 8'h84;  8'h05: key_map = 8'h85;  8'h06: key_map = 8'h86;
      8'h04: key_map = 8'h87;
      8'h1C: key_map = 8'h88;  8'h1B: key_map = 8'h89;  8'h23: key_map = 8'h8A;
      8'h2B: key_map = 8'h8B;  8'h34: key_map = 8'h8C;  8'h0C: key_map = 8'h8D;
      8'h03: key_map = 8'h8E;  8'h0B: key_map = 8'h8F;
      8'h15: key_map = 8'h90;  8'h1D: key_map = 8'h91;  8'h24: key_map = 8'h92;
      8'h2D: key_map = 8'h93;  8'h2C: key_map = 8'h94;  8'h83: key_map = 8'h95;
      8'h0A: key_map = 8'h96;  8'h01: key_map = 8'h97;
      8'h16: key_map = 8'h98;  8'h1E: key_map = 8'h99;  8'h26: key_map = 8'h9A;
      8'h25: key_map = 8'h9B;  8'h2E: key_map = 8'h9C;  8'h76: key_map = 8'h9D;
      8'h0D: key_map = 8'h9E;  8'h58: key_map = 8'h9F;
      8'h45: key_map = 8'hA0;  8'h46: key_map = 8'hA1;  8'h3E: key_map = 8'hA2;
      8'h3D: key_map = 8'hA3;  8'h36: key_map = 8'hA4;  8'h66: key_map = 8'hA5;
      8'h55: key_map = 8'hA6;  8'h4E: key_map = 8'hA7;
      8'h4D: key_map = 8'hA8;  8'h44: key_map = 8'hA9;  8'h43: key_map = 8'hAA;
      8'h3C: key_map = 8'hAB;  8'h35: key_map = 8'hAC;  8'h09: key_map = 8'hAD;
      8'h54: key_map = 8'hAE;  8'h52: key_map = 8'hAF;
      8'h5A: key_map = 8'hB0;  8'h4B: key_map = 8'hB1;  8'h42: key_map = 8'hB2;
      8'h3B: key_map = 8'hB3;  8'h33: key_map = 8'hB4;  8'h0E: key_map = 8'hB5;
      8'h4C: key_map = 8'hB6;  8'h5D: key_map = 8'hB7;
      8'h29: key_map = 8'hB8;  8'h11: key_map = 8'hB9;  8'h3A: key_map = 8'hBA;
      8'h31: key_map = 8'hBB;  8'h32: key_map = 8'hBC;  8'h5B: key_map = 8'hBD;
      8'h49: key_map = 8'hBE;  8'h41: key_map = 8'hBF;
      8'h14: key_map = 8'hC0;  8'h75: key_map = 8'hC1;  8'h72: key_map = 8'hC2;
      8'h6B: key_map = 8'hC3;  8'h74: key_map = 8'hC4;
      default: key_map = 8'h00;
    endcase
  endfunction

  logic [2:0]      kclk_q, kclk_d;
  logic [1:0]      kdat_q, kdat_d;
  logic [3:0]      bit_cnt_q, bit_cnt_d;
  logic [10:0]     frame_q, frame_d;
  logic [TO_W-1:0] to_cnt_q, to_cnt_d;
  logic            rx_ok_q, rx_ok_d;
  logic [7:0]      rx_byte_q, rx_byte_d;
  logic            strobe_q, strobe_d;
  state_t          state_q, state_d;
  logic [2:0]      pause_cnt_q, pause_cnt_d;
  logic [8:0][7:0] matrix_q, matrix_d;
  logic [11:1]     fn_q, fn_d;
  logic [5:0]      held_q, held_d;
  logic [2:0]      mod_q, mod_d;
  logic [7:0]      key_data_q, key_data_d;
  logic            fall_c, apply_c, make_c, ext_c;
  logic [7:0]      map_c;
  logic            addr_unused_c;

  assign addr_unused_c = ^addr[7:0];
  assign fall_c        = kclk_q[2] & ~kclk_q[1];

  // Synchronisers, frame shift register, bit counter and inactivity timeout.
  always_comb begin
    kclk_d    = {kclk_q[1:0], ps2_kbd_clk};
    kdat_d    = {kdat_q[0], ps2_kbd_data};
    bit_cnt_d = bit_cnt_q;
    frame_d   = frame_q;
    to_cnt_d  = to_cnt_q;
    rx_ok_d   = 1'b0;
    rx_byte_d = rx_byte_q;
    strobe_d  = rx_ok_q;
    if (fall_c) begin
      to_cnt_d = '0;
      frame_d  = {kdat_q[1], frame_q[10:1]};
      if (bit_cnt_q == 4'd10) begin
        bit_cnt_d = 4'd0;
        if (!frame_d[0] && frame_d[10] && (^frame_d[9:1])) begin
          rx_ok_d   = 1'b1;
          rx_byte_d = frame_d[8:1];
        end
      end else begin
        bit_cnt_d = bit_cnt_q + 4'd1;
      end
    end else if (bit_cnt_q != 4'd0) begin
      if (to_cnt_q == TO_W'(TIMEOUT)) begin
        bit_cnt_d = 4'd0;
        to_cnt_d  = '0;
      end else begin
        to_cnt_d = to_cnt_q + TO_W'(1);
      end
    end else begin
      to_cnt_d = '0;
    end
  end

  // Prefix decoder: tracks E0/F0/E1 and issues one apply per key event.
  always_comb begin
    state_d     = state_q;
    pause_cnt_d = pause_cnt_q;
    apply_c     = 1'b0;
    make_c      = 1'b0;
    ext_c       = 1'b0;
    if (strobe_q) begin
      case (state_q)
        ST_IDLE: begin
          if (rx_byte_q == 8'hE0) begin
            state_d = ST_EXT;
          end else if (rx_byte_q == 8'hF0) begin
            state_d = ST_BRK;
          end else if (rx_byte_q == 8'hE1) begin
            state_d     = ST_PAUSE;
            pause_cnt_d = 3'd0;
          end else begin
            apply_c = 1'b1;
            make_c  = 1'b1;
          end
        end
        ST_EXT: begin
          if (rx_byte_q == 8'hF0) begin
            state_d = ST_EXT_BRK;
          end else begin
            apply_c = 1'b1;
            make_c  = 1'b1;
            ext_c   = 1'b1;
            state_d = ST_IDLE;
          end
        end
        ST_BRK: begin
          apply_c = 1'b1;
          state_d = ST_IDLE;
        end
        ST_EXT_BRK: begin
          apply_c = 1'b1;
          ext_c   = 1'b1;
          state_d = ST_IDLE;
        end
        ST_PAUSE: begin
          if (pause_cnt_q == 3'd6) begin
            pause_cnt_d = 3'd0;
            state_d     = ST_IDLE;
          end else begin
            pause_cnt_d = pause_cnt_q + 3'd1;
          end
        end
        default: state_d = ST_IDLE;
      endcase
    end
  end

  // Apply a key event to the matrix, the F-key state and the modifiers.
  always_comb begin
    matrix_d = matrix_q;
    fn_d     = fn_q;
    held_d   = held_q;
    map_c    = key_map(rx_byte_q);
    if (apply_c) begin
      if (map_c[7]) matrix_d[map_c[6:3]][map_c[2:0]] = ~make_c;
      case (rx_byte_q)
        8'h05: fn_d[1]  = make_c;
        8'h06: fn_d[2]  = make_c;
        8'h04: fn_d[3]  = make_c;
        8'h0C: fn_d[4]  = make_c;
        8'h03: fn_d[5]  = make_c;
        8'h0B: fn_d[6]  = make_c;
        8'h83: fn_d[7]  = make_c;
        8'h0A: fn_d[8]  = make_c;
        8'h01: fn_d[9]  = make_c;
        8'h09: fn_d[10] = make_c;
        8'h78: fn_d[11] = make_c;
        default: fn_d = fn_q;
      endcase
      case (rx_byte_q)
        8'h12: held_d[0] = make_c;
        8'h59: held_d[1] = make_c;
        8'h14: if (ext_c) held_d[3] = make_c; else held_d[2] = make_c;
        8'h11: if (ext_c) held_d[5] = make_c; else held_d[4] = make_c;
        default: held_d = held_q;
      endcase
    end
    mod_d = {held_d[5] | held_d[4], held_d[3] | held_d[2], held_d[1] | held_d[0]};
  end

  // Row read-out: AND of every selected row; row 8 only when no row line is low.
  always_comb begin
    key_data_d = 8'hFF;
    for (int unsigned r = 0; r < 8; r++) begin
      if (!addr[8+r]) key_data_d = key_data_d & matrix_q[r];
    end
    if (addr[15:8] == 8'hFF) key_data_d = key_data_d & matrix_q[8];
  end

  // State registers.
  always_ff @(posedge clk_sys or negedge rst_n) begin
    if (!rst_n) begin
      kclk_q      <= 3'b111;
      kdat_q      <= 2'b11;
      bit_cnt_q   <= 4'd0;
      frame_q     <= '0;
      to_cnt_q    <= '0;
      rx_ok_q     <= 1'b0;
      rx_byte_q   <= 8'h00;
      strobe_q    <= 1'b0;
      state_q     <= ST_IDLE;
      pause_cnt_q <= 3'd0;
      matrix_q    <= '1;
      fn_q        <= '0;
      held_q      <= '0;
      mod_q       <= 3'd0;
      key_data_q  <= 8'hFF;
    end else begin
      kclk_q      <= kclk_d;
      kdat_q      <= kdat_d;
      bit_cnt_q   <= bit_cnt_d;
      frame_q     <= frame_d;
      to_cnt_q    <= to_cnt_d;
      rx_ok_q     <= rx_ok_d;
      rx_byte_q   <= rx_byte_d;
      strobe_q    <= strobe_d;
      state_q     <= state_d;
      pause_cnt_q <= pause_cnt_d;
      matrix_q    <= matrix_d;
      fn_q        <= fn_d;
      held_q      <= held_d;
      mod_q       <= mod_d;
      key_data_q  <= key_data_d;
    end
  end

  assign key_data = key_data_q;
  assign Fn       = fn_q;
  assign mod      = mod_q;

endmodule

// File: tb/tb_ps2_key_matrix.sv
// Directed bench for ps2_key_matrix: PS/2 frames in, scoreboarded matrix/Fn/mod out.
module tb_ps2_key_matrix;

  localparam int unsigned TO   = 200;
  localparam int          HALF = 20;

  logic        clk_sys = 1'b0;
  logic        rst_n   = 1'b0;
  logic        kclk    = 1'b1;
  logic        kdat    = 1'b1;
  logic [15:0] addr    = 16'hFFFF;
  logic [7:0]  key_data;
  logic [11:1] fn_w;
  logic [2:0]  mod_w;

  typedef struct {
    int         kind;
    logic [10:0] val;
  } exp_t;

  exp_t sb[$];
  int   tests = 0;
  int   fails = 0;

  ps2_key_matrix #(.TIMEOUT(TO)) dut (
    .clk_sys      (clk_sys),
    .rst_n        (rst_n),
    .ps2_kbd_clk  (kclk),
    .ps2_kbd_data (kdat),
    .addr         (addr),
    .key_data     (key_data),
    .Fn           (fn_w),
    .mod          (mod_w)
  );

  always #5 clk_sys = ~clk_sys;

  initial begin
    #2ms;
    $display("FAIL watchdog: run exceeded time limit");
    $fatal(1, "watchdog");
  end

  task automatic cyc(input int n);
    repeat (n) @(posedge clk_sys);
    #1;
  endtask

  function automatic logic [10:0] mk(input logic [7:0] b, input logic bad);
    return {1'b1, (~^b) ^ bad, b, 1'b0};
  endfunction

  task automatic ps2_bits(input logic [10:0] f, input int n);
    for (int i = 0; i < n; i++) begin
      kdat = f[i];
      cyc(HALF);
      kclk = 1'b0;
      cyc(HALF);
      kclk = 1'b1;
    end
    kdat = 1'b1;
  endtask

  task automatic send(input logic [7:0] b);
    ps2_bits(mk(b, 1'b0), 11);
    cyc(HALF);
  endtask

  task automatic expect_val(input int kind, input logic [10:0] v);
    exp_t e;
    e.kind = kind;
    e.val  = v;
    sb.push_back(e);
  endtask

  task automatic check_out(input string name);
    exp_t        e;
    logic [10:0] obs;
    tests++;
    if (sb.size() == 0) begin
      fails++;
      $error("FAIL %s: no expected value queued", name);
      return;
    end
    e = sb.pop_front();
    case (e.kind)
      0:       obs = {3'b000, key_data};
      1:       obs = fn_w;
      default: obs = {8'h00, mod_w};
    endcase
    assert (obs === e.val) else begin
      fails++;
      $error("FAIL %s: observed %h expected %h", name, obs, e.val);
    end
  endtask

  task automatic probe(input logic [15:0] a, input logic [7:0] exp, input string name);
    addr = a;
    expect_val(0, {3'b000, exp});
    cyc(1);
    check_out(name);
  endtask

  task automatic chk_fn(input logic [10:0] exp, input string name);
    expect_val(1, exp);
    check_out(name);
  endtask

  task automatic chk_mod(input logic [2:0] exp, input string name);
    expect_val(2, {8'h00, exp});
    check_out(name);
  endtask

  initial begin
    cyc(3);
    addr = 16'hFEFE;
    expect_val(0, 11'h0FF);
    check_out("key_in_reset");
    rst_n = 1'b1;
    cyc(3);
    probe(16'hFEFE, 8'hFF, "reset_key");
    chk_fn(11'h000, "reset_fn");
    chk_mod(3'b000, "reset_mod");

    // Basic make / break of Z.
    send(8'h1A);
    probe(16'hFEFE, 8'hFD, "press_z");
    send(8'hF0); send(8'h1A);
    probe(16'hFEFE, 8'hFF, "release_z");

    // Corrupt frames are dropped and do not desynchronise the receiver.
    ps2_bits(mk(8'h1A, 1'b1), 11); cyc(HALF);
    probe(16'hFEFE, 8'hFF, "bad_parity");
    send(8'h1A);
    probe(16'hFEFE, 8'hFD, "after_bad_parity");
    send(8'hF0); send(8'h1A);
    ps2_bits({1'b0, ~^8'h1A, 8'h1A, 1'b0}, 11); cyc(HALF);
    probe(16'hFEFE, 8'hFF, "bad_stop");
    send(8'h1A);
    probe(16'hFEFE, 8'hFD, "after_bad_stop");
    send(8'hF0); send(8'h1A);

    // Partial frame abandoned by the inactivity timeout.
    ps2_bits(mk(8'h1A, 1'b0), 6);
    cyc(TO + 10);
    send(8'h1A);
    probe(16'hFEFE, 8'hFD, "after_timeout");
    send(8'hF0); send(8'h1A);
    probe(16'hFEFE, 8'hFF, "timeout_release");

    // Extended right ctrl and F11.
    send(8'hE0); send(8'h14); send(8'h78);
    chk_mod(3'b010, "rctrl_press");
    chk_fn(11'h400, "f11_press");
    send(8'hE0); send(8'hF0); send(8'h14);
    chk_mod(3'b000, "rctrl_release");
    chk_fn(11'h400, "f11_still_held");
    send(8'hF0); send(8'h78);
    chk_fn(11'h000, "f11_release");

    // Left/right shift held separately; shared matrix bit follows last event.
    send(8'h12);
    chk_mod(3'b001, "lshift_press");
    probe(16'hFEFE, 8'hFE, "shift_bit");
    send(8'h59);
    send(8'hF0); send(8'h12);
    chk_mod(3'b001, "rshift_still_held");
    probe(16'hFEFE, 8'hFF, "shared_bit_last_event");
    send(8'hF0); send(8'h59);
    chk_mod(3'b000, "rshift_release");

    // Row selection.
    send(8'h1A); send(8'h21);
    probe(16'hFEFE, 8'hF5, "row0_z_c");
    probe(16'hFDFD, 8'hFF, "row1_idle");
    send(8'h1C);
    probe(16'h0000, 8'hF4, "all_rows_and");
    probe(16'hFFFF, 8'hFF, "row8_idle");
    send(8'h14);
    probe(16'hFFFF, 8'hFE, "row8_ctrl");
    probe(16'h0000, 8'hF4, "row8_not_in_all");
    chk_mod(3'b010, "lctrl_press");
    send(8'hF0); send(8'h14);
    chk_mod(3'b000, "lctrl_release");

    // Typematic repeat leaves state unchanged.
    send(8'h1A);
    probe(16'hFEFE, 8'hF5, "typematic");

    // Pause sequence is swallowed entirely.
    send(8'hE1); send(8'h14); send(8'h77); send(8'hE1);
    send(8'hF0); send(8'h14); send(8'hF0); send(8'h77);
    chk_mod(3'b000, "pause_discard");
    probe(16'hFFFF, 8'hFF, "pause_row8");
    send(8'h14);
    chk_mod(3'b010, "after_pause");
    send(8'hF0); send(8'h14);

    // F1 is both a matrix key and an Fn bit.
    send(8'h05);
    chk_fn(11'h001, "f1_press");
    probe(16'hFEFE, 8'hD5, "f1_matrix");

    // Reset pulse mid-frame clears everything; next frame decodes cleanly.
    ps2_bits(mk(8'h2A, 1'b0), 5);
    rst_n = 1'b0;
    #2;
    expect_val(0, 11'h0FF);
    check_out("midframe_reset_key");
    chk_fn(11'h000, "midframe_reset_fn");
    chk_mod(3'b000, "midframe_reset_mod");
    cyc(1);
    rst_n = 1'b1;
    cyc(5);
    probe(16'hFEFE, 8'hFF, "after_reset");
    send(8'h1A);
    probe(16'hFEFE, 8'hFD, "post_reset_decode");

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
